fxcs: RTL and testbench

FXCS -- requirements
Module: fxcs

---
 rtl/fxcs.sv | 70 +++++++
 tb/tb_fxcs.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fxcs.sv
// fxcs: registered one-hot select of the set bit nearest to a target index
module fxcs #(
    parameter int WIDTH = 16,
    parameter int ABSTRACT_MODEL = 0,
    localparam int TW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [TW-1:0]    i_target,
    input  logic [WIDTH-1:0] i_vector,
    output logic [WIDTH-1:0] o_onehot
);

    logic [WIDTH-1:0] sel;

    if (ABSTRACT_MODEL != 0) begin : g_abs
        int best;
        int d;
        // linear scan in ascending index; strict < keeps the lower bit on ties
        always_comb begin
            sel = '0;
            best = 1 << 30;
            d = 0;
            for (int i = 0; i < WIDTH; i++) begin
                d = (i > int'(i_target)) ? i - int'(i_target) : int'(i_target) - i;
                if (i_vector[i] && d < best) begin
                    best = d;
                    sel = '0;
                    sel[i] = 1'b1;
                end
            end
        end
    end else begin : g_str
        logic [WIDTH-1:0] lo_mask, lo_set, hi_set, lo_rev, lo_rev_oh, lo_oh, hi_oh;
        logic [TW-1:0]    lo_idx, hi_idx, lo_dist, hi_dist;
        logic             pick_lo;
        // split at the target: nearest below is the highest set bit of the lower part
        // (isolated on the bit-reversed vector), nearest above is the lowest set bit
        // of the upper part; a target past the top leaves the upper part empty
        always_comb begin
            lo_mask = '0;
            lo_rev = '0;
            lo_oh = '0;
            lo_idx = '0;
            hi_idx = '0;
            for (int i = 0; i < WIDTH; i++) lo_mask[i] = TW'(i) <= i_target;
            lo_set = i_vector & lo_mask;
            hi_set = i_vector & ~lo_mask;
            for (int i = 0; i < WIDTH; i++) lo_rev[i] = lo_set[WIDTH-1-i];
            lo_rev_oh = lo_rev & -lo_rev;
            for (int i = 0; i < WIDTH; i++) lo_oh[i] = lo_rev_oh[WIDTH-1-i];
            hi_oh = hi_set & -hi_set;
            for (int i = 0; i < WIDTH; i++) begin
                lo_idx = lo_idx | (lo_oh[i] ? TW'(i) : '0);
                hi_idx = hi_idx | (hi_oh[i] ? TW'(i) : '0);
            end
            lo_dist = i_target - lo_idx;
            hi_dist = hi_idx - i_target;
            pick_lo = |lo_set && (~|hi_set || lo_dist <= hi_dist);
            sel = pick_lo ? lo_oh : hi_oh;
        end
    end

    // output register, cleared asynchronously by reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_onehot <= '0;
        else         o_onehot <= sel;
    end

endmodule

// File: tb/tb_fxcs.sv
// tb_fxcs: directed and swept checks of fxcs for widths 16, 9 and 7, both variants
module tb_fxcs;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;

    logic [3:0]  t16 = 4'd7;
    logic [15:0] v16 = 16'hFFFF;
    logic [15:0] o16a, o16s;
    logic [3:0]  t9 = '0;
    logic [8:0]  v9 = '0;
    logic [8:0]  o9a, o9s;
    logic [2:0]  t7 = '0;
    logic [6:0]  v7 = '0;
    logic [6:0]  o7a, o7s;

    always #5 clk = ~clk;

    fxcs #(.WIDTH(16), .ABSTRACT_MODEL(1)) u16a (.i_clk(clk), .i_rstn(rstn), .i_target(t16), .i_vector(v16), .o_onehot(o16a));
    fxcs #(.WIDTH(16), .ABSTRACT_MODEL(0)) u16s (.i_clk(clk), .i_rstn(rstn), .i_target(t16), .i_vector(v16), .o_onehot(o16s));
    fxcs #(.WIDTH(9),  .ABSTRACT_MODEL(1)) u9a  (.i_clk(clk), .i_rstn(rstn), .i_target(t9),  .i_vector(v9),  .o_onehot(o9a));
    fxcs #(.WIDTH(9),  .ABSTRACT_MODEL(0)) u9s  (.i_clk(clk), .i_rstn(rstn), .i_target(t9),  .i_vector(v9),  .o_onehot(o9s));
    fxcs #(.WIDTH(7),  .ABSTRACT_MODEL(1)) u7a  (.i_clk(clk), .i_rstn(rstn), .i_target(t7),  .i_vector(v7),  .o_onehot(o7a));
    fxcs #(.WIDTH(7),  .ABSTRACT_MODEL(0)) u7s  (.i_clk(clk), .i_rstn(rstn), .i_target(t7),  .i_vector(v7),  .o_onehot(o7s));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ring search outward from the target, lower side first so ties go low
    function automatic logic [63:0] nearest(input int w, input int t, input logic [63:0] v);
        for (int d = 0; d < 128; d++) begin
            if (t - d >= 0 && t - d < w && v[t-d]) return 64'(1) << (t - d);
            if (t + d < w && v[t+d]) return 64'(1) << (t + d);
        end
        return '0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic dir16(input string tag, input logic [3:0] t, input logic [15:0] v, input logic [15:0] exp);
        t16 = t;
        v16 = v;
        step();
        check({tag, "_abs"}, o16a, exp);
        check({tag, "_str"}, o16s, exp);
    endtask

    initial begin
        #12;
        check("rst_16a", o16a, 0);
        check("rst_16s", o16s, 0);
        check("rst_9a", o9a, 0);
        check("rst_7s", o7s, 0);
        rstn = 1'b1;
        step();
        check("first_edge_abs", o16a, 16'h0080);
        check("first_edge_str", o16s, 16'h0080);

        dir16("d3_vs_d5", 4'd5, 16'h0101, 16'h0100);
        dir16("tie_low", 4'd4, 16'h0044, 16'h0004);
        dir16("all_ones", 4'd7, 16'hFFFF, 16'h0080);
        dir16("all_zero", 4'd7, 16'h0000, 16'h0000);
        dir16("top_only", 4'd0, 16'h8000, 16'h8000);
        dir16("tie_edge", 4'd1, 16'h0005, 16'h0001);

        t7 = 3'd6;
        v7 = 7'h01;
        step();
        check("nowrap_abs", o7a, 7'h01);
        check("nowrap_str", o7s, 7'h01);
        t7 = 3'd7;
        v7 = 7'h05;
        step();
        check("tgt_past_top_abs", o7a, 7'h04);
        check("tgt_past_top_str", o7s, 7'h04);

        dir16("hold", 4'd7, 16'hFFFF, 16'h0080);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_abs", o16a, 0);
        check("async_rst_str", o16s, 0);
        #2 rstn = 1'b1;
        #1;
        check("rst_no_edge", o16a, 0);
        step();
        check("resume_abs", o16a, 16'h0080);
        check("resume_str", o16s, 16'h0080);

        for (int t = 0; t < 8; t++)
            for (int v = 0; v < 128; v++) begin
                t7 = 3'(t);
                v7 = 7'(v);
                step();
                check($sformatf("w7_abs t=%0d v=%h", t, v), o7a, nearest(7, t, 64'(v)));
                check($sformatf("w7_str t=%0d v=%h", t, v), o7s, nearest(7, t, 64'(v)));
                check($sformatf("w7_xv t=%0d v=%h", t, v), o7s, o7a);
            end

        for (int t = 0; t < 16; t++)
            for (int v = 0; v < 512; v++) begin
                t9 = 4'(t);
                v9 = 9'(v);
                step();
                check($sformatf("w9_abs t=%0d v=%h", t, v), o9a, nearest(9, t, 64'(v)));
                check($sformatf("w9_str t=%0d v=%h", t, v), o9s, nearest(9, t, 64'(v)));
                check($sformatf("w9_xv t=%0d v=%h", t, v), o9s, o9a);
            end

        for (int t = 0; t < 16; t++)
            for (int n = 0; n < 150; n++) begin
                logic [15:0] v;
                v = (n < 16) ? 16'(1) << n : (n == 16) ? 16'h0000 : (n == 17) ? 16'hFFFF : 16'($urandom);
                t16 = 4'(t);
                v16 = v;
                step();
                check($sformatf("w16_abs t=%0d v=%h", t, v), o16a, nearest(16, t, 64'(v)));
                check($sformatf("w16_str t=%0d v=%h", t, v), o16s, nearest(16, t, 64'(v)));
                check($sformatf("w16_xv t=%0d v=%h", t, v), o16s, o16a);
            end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
